// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the LED matrix memory-side blocks.
// The frame reader FSM encoding and the return FIFO sizing live here.
package led_matrix_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 25;
    localparam int DEFAULT_FIFO_DEPTH    = 16;
    localparam int FIFO_PTR_W            = $clog2(DEFAULT_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through and an occupancy count.
// DEPTH must be a power of two; pointers wrap naturally.
module sync_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [CNT_W-2:0] wr_ptr;
    logic [CNT_W-2:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & valid;
    // Head byte is forced to zero when empty so the stream output is clean out of reset.
    assign rd_data = valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Streams a contiguous frame-RAM byte region through one arbiter port into a valid/ready byte stream.
// Optional return-path protocol checking is built when FRAME_READER_ERR_CHECK_EN is defined.
module frame_buffer_reader
    import led_matrix_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int LENGTH_WIDTH  = 16,
    parameter int FIFO_DEPTH    = 1 << FIFO_PTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [LENGTH_WIDTH-1:0]  length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_wr,
    output logic [7:0]               mem_data,
    input  logic                     mem_full,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_rvalid,
    output logic [7:0]               pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     err,
    output logic [1:0]               dbg_state
);

    // Handshakes: a memory request transfers on a rising edge with mem_req=1 and mem_full=0,
    // mem_req/mem_address hold until then; a stream byte transfers when pix_valid & pix_ready.
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CTR_W = LENGTH_WIDTH + 1;

    reader_state_t            state;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [CTR_W-1:0]         len_q;
    logic [CTR_W-1:0]         issued_q;
    logic [CTR_W-1:0]         popped_q;
    logic [CTR_W-1:0]         issued_nxt;
    logic [CTR_W-1:0]         popped_nxt;
    logic [CW-1:0]            credit_q;
    logic [CW-1:0]            credit_nxt;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_wr;
    logic                     fifo_full;
    logic                     accept;
    logic                     pop;
    logic                     in_xfer;
    logic                     load_ok;

    assign accept     = mem_req & ~mem_full;
    assign pop        = pix_valid & pix_ready;
    assign in_xfer    = (state == FETCH) || (state == DRAIN);
    assign issued_nxt = issued_q + CTR_W'(accept);
    assign popped_nxt = popped_q + CTR_W'(pop);
    assign credit_nxt = credit_q + CW'(accept) - CW'(pop);
    // Credit is requests in flight plus bytes parked in the FIFO, so every return has a slot.
    assign load_ok    = (issued_nxt < len_q) && (credit_nxt < CW'(FIFO_DEPTH));

    assign mem_wr    = 1'b0;
    assign mem_data  = 8'h00;
    assign dbg_state = state;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (mem_rdata),
        .rd_en   (pix_ready),
        .rd_data (pix_data),
        .valid   (pix_valid),
        .full    (fifo_full),
        .count   (fifo_count)
    );

`ifdef FRAME_READER_ERR_CHECK_EN
    logic [CW-1:0] outstanding;
    logic          spurious;
    logic          overrun;

    assign outstanding = credit_q - fifo_count;
    assign spurious    = mem_rvalid & in_xfer & (outstanding == '0);
    assign overrun     = mem_rvalid & fifo_full;
    assign fifo_wr     = mem_rvalid & in_xfer & ~spurious & ~fifo_full;

    always_ff @(posedge clk) begin
        if (reset)                   err <= 1'b0;
        else if (spurious | overrun) err <= 1'b1;
    end
`else
    // Returns outside a transfer are late pulses from an aborted one and are dropped.
    assign fifo_wr = mem_rvalid & in_xfer & ~fifo_full;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_req     <= 1'b0;
            mem_address <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            credit_q    <= '0;
        end else begin
            done     <= 1'b0;
            credit_q <= credit_nxt;
            issued_q <= issued_nxt;
            popped_q <= popped_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_address;
                        len_q    <= {1'b0, length};
                        issued_q <= '0;
                        popped_q <= '0;
                        if (length != '0) begin
                            state       <= FETCH;
                            busy        <= 1'b1;
                            mem_req     <= 1'b1;
                            mem_address <= base_address;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (accept && (issued_nxt == len_q)) begin
                        mem_req <= 1'b0;
                        state   <= DRAIN;
                    end else if (!mem_req || accept) begin
                        mem_req <= load_ok;
                        if (load_ok) mem_address <= base_q + ADDRESS_WIDTH'(issued_nxt);
                    end
                end
                DRAIN: begin
                    if (popped_nxt == len_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: arbiter/RAM responder, stream sink and scoreboard.
// Exercises the extra error checks when FRAME_READER_ERR_CHECK_EN is defined.
module tb_frame_buffer_reader;
    import led_matrix_pkg::*;

    localparam int AW    = 25;
    localparam int LW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, mem_req, mem_wr, pix_valid, err;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data, pix_data;
    logic [1:0]    dbg_state;
    logic          mem_full = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;
    logic          pix_ready = 1'b0;

    frame_buffer_reader #(.ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address), .length(length),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_address(mem_address), .mem_wr(mem_wr),
        .mem_data(mem_data), .mem_full(mem_full), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .err(err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            resp_due_q[$];
    logic [7:0]    resp_dat_q[$];
    int errors = 0;
    int checks = 0;
    int lat = 2, stall_after = 0, stall_len = 0, stall_cnt = 0;
    bit full_force = 0, ready_en = 0, inject = 0;
    int n_acc = 0, n_pop = 0, acc_first = -1, acc_last = -1, last_pop_cyc = -1;
    int done_cnt = 0, done_cyc = -1, rv_cnt = 0, start_edge = 0;
    bit req_seen = 0, pv_seen = 0;

    function automatic logic [7:0] ram_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[24:17] ^ 8'hA5;
    endfunction

    // Arbiter/RAM responder and stream sink, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin
        bit acc;
        logic [7:0] e;
        acc = 0;
        if (stall_cnt > 0) begin
            mem_full = 1'b1;
            stall_cnt--;
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: mem_req=%0b required 1 at cycle %0d", mem_req, cyc);
            end
        end else begin
            mem_full = full_force;
        end

        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        if (inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'hEE;
            inject     = 0;
        end else if (resp_due_q.size() > 0 && resp_due_q[0] == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = resp_dat_q.pop_front();
            void'(resp_due_q.pop_front());
            rv_cnt++;
        end

        if (mem_req === 1'b1) begin
            req_seen = 1;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL req_extra: mem_address=%h required no request", mem_address);
            end else if (mem_address !== exp_addr_q[0]) begin
                errors++;
                $display("FAIL req_addr: mem_address=%h required %h", mem_address, exp_addr_q[0]);
            end
            if (!mem_full) begin
                acc = 1;
                if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
                resp_due_q.push_back(cyc + lat);
                resp_dat_q.push_back(ram_byte(mem_address));
                if (n_acc == 0) acc_first = cyc;
                acc_last = cyc;
                n_acc++;
                if (n_acc == stall_after) stall_cnt = stall_len;
            end
        end

        pix_ready = ready_en;
        if (pix_valid === 1'b1) pv_seen = 1;
        if (pix_valid === 1'b1 && pix_ready) begin
            n_pop++;
            last_pop_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pix_extra: pix_data=%h required no byte", pix_data);
            end else begin
                e = exp_q.pop_front();
                if (pix_data !== e) begin
                    errors++;
                    $display("FAIL pix_data: got %h required %h", pix_data, e);
                end
            end
        end

        if (acc) begin
            checks++;
            if (n_acc - n_pop > DEPTH) begin
                errors++;
                $display("FAIL credit: accepted-popped=%0d required <= %0d", n_acc - n_pop, DEPTH);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        n_acc = 0; n_pop = 0; done_cnt = 0; req_seen = 0; pv_seen = 0;
        acc_first = -1; acc_last = -1;
        for (int i = 0; i < len; i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(ram_byte(a));
        end
        base_address = b;
        length = LW'(len);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_done(input int max_cycles);
        int i;
        i = 0;
        while (done_cnt == 0 && i < max_cycles) begin
            tick(1);
            i++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required a pulse", max_cycles);
        end
        tick(2);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({busy, done, mem_req, mem_wr, pix_valid, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done/req/wr/valid/err=%b required 000000",
                     {busy, done, mem_req, mem_wr, pix_valid, err});
        end
        checks++;
        if (mem_address !== '0 || mem_data !== 8'h00 || pix_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h pix=%h required 0", mem_address, mem_data, pix_data);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, IDLE);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        lat = 2; ready_en = 1;
        start_xfer(25'h100, 8);
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b1 || mem_address !== 25'h100) begin
            errors++;
            $display("FAIL first_req: busy=%b req=%b addr=%h required 1 1 100", busy, mem_req, mem_address);
        end
        wait_done(100);
        checks++;
        if (acc_first != start_edge || acc_last != start_edge + 7) begin
            errors++;
            $display("FAIL basic_span: accepts %0d..%0d required %0d..%0d",
                     acc_first, acc_last, start_edge, start_edge + 7);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_pop_cyc + 1) begin
            errors++;
            $display("FAIL basic_done: count=%0d at %0d required 1 at %0d", done_cnt, done_cyc, last_pop_cyc + 1);
        end
        checks++;
        if (n_pop != 8 || exp_q.size() != 0 || exp_addr_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: pops=%0d left=%0d busy=%b required 8 0 0", n_pop, exp_q.size(), busy);
        end
    endtask

    task automatic test_mem_full();
        stall_after = 2; stall_len = 3;
        start_xfer(25'h100, 8);
        wait_done(100);
        stall_after = 0;
        checks++;
        if (n_acc != 8 || acc_last != start_edge + 10) begin
            errors++;
            $display("FAIL stall_span: accepts=%0d last=%0d required 8 last=%0d", n_acc, acc_last, start_edge + 10);
        end
        checks++;
        if (done_cnt != 1 || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: done=%0d left=%0d required 1 0", done_cnt, exp_q.size());
        end
    endtask

    task automatic test_credit();
        ready_en = 0;
        start_xfer(25'h2000, 40);
        tick(50);
        checks++;
        if (n_acc != 16 || n_pop != 0 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL credit_stop: accepts=%0d pops=%0d valid=%b required 16 0 1", n_acc, n_pop, pix_valid);
        end
        ready_en = 1;
        wait_done(400);
        checks++;
        if (n_acc != 40 || n_pop != 40 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL credit_drain: accepts=%0d pops=%0d done=%0d required 40 40 1", n_acc, n_pop, done_cnt);
        end
    endtask

    task automatic test_zero_length();
        start_xfer(25'h500, 0);
        tick(3);
        checks++;
        if (done_cnt != 1 || done_cyc != start_edge) begin
            errors++;
            $display("FAIL zero_done: count=%0d at %0d required 1 at %0d", done_cnt, done_cyc, start_edge);
        end
        checks++;
        if (req_seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_req: req_seen=%0b busy=%b required 0 0", req_seen, busy);
        end
    endtask

    task automatic test_addr_wrap();
        start_xfer(25'h1FFFFFE, 4);
        wait_done(60);
        checks++;
        if (n_acc != 4 || n_pop != 4 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: accepts=%0d pops=%0d required 4 4", n_acc, n_pop);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        lat = 30; ready_en = 0;
        start_xfer(25'h600, 5);
        i = 0;
        while (n_acc < 5 && i < 30) begin
            tick(1);
            i++;
        end
        checks++;
        if (n_acc != 5 || busy !== 1'b1 || dbg_state !== DRAIN) begin
            errors++;
            $display("FAIL mid_setup: accepts=%0d busy=%b state=%0d required 5 1 %0d", n_acc, busy, dbg_state, DRAIN);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        pv_seen = 0; rv_cnt = 0; ready_en = 1;
        i = 0;
        while (resp_due_q.size() > 0 && i < 80) begin
            tick(1);
            i++;
        end
        tick(2);
        checks++;
        if (rv_cnt != 5 || pv_seen) begin
            errors++;
            $display("FAIL mid_late: rvalids=%0d valid_seen=%0b required 5 0", rv_cnt, pv_seen);
        end
        checks++;
        if (busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_idle: busy=%b state=%0d required 0 %0d", busy, dbg_state, IDLE);
        end
        lat = 2;
        start_xfer(25'h700, 6);
        wait_done(100);
        checks++;
        if (n_pop != 6 || done_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_restart: pops=%0d done=%0d required 6 1", n_pop, done_cnt);
        end
    endtask

`ifdef FRAME_READER_ERR_CHECK_EN
    task automatic test_err();
        full_force = 1;
        start_xfer(25'h800, 4);
        tick(2);
        checks++;
        if (mem_req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_setup: req=%b err=%b required 1 0", mem_req, err);
        end
        inject = 1;
        tick(3);
        checks++;
        if (err !== 1'b1 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_spurious: err=%b valid=%b required 1 0", err, pix_valid);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        full_force = 0;
        exp_q.delete();
        exp_addr_q.delete();
        tick(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
    endtask
`else
    task automatic test_err();
        tick(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: err=%b required 0", err);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_mem_full();
        test_credit();
        test_zero_length();
        test_addr_wrap();
        test_reset_mid();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
